mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arb_pkg.sv | 31 +++
 rtl/mul_arbiter_mul.sv | 34 +++
 rtl/mul_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mul_arb_pkg.sv
// mul_arbiter shared definitions.
// Default sizes, state encoding and round-robin helpers.
package mul_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int MUL_LAT_DEF = 2;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TAG_W = width_of(NREQ_DEF);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  // base + off, wrapped into 0..n-1 (base < n, off < n)
  function automatic int rr_add(
    input int base,
    input int off,
    input int n
  );
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/mul_arbiter_mul.sv
// mul: pipelined 32x32 multiplier, low 32 bits.
// C is valid LAT cycles after A/B become stable.
module mul #(
  parameter int LAT = 2
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] C
);

  logic [31:0] prod;
  logic [31:0] pipe_q [LAT];

  assign prod = A * B;

  // product pipeline, one stage per cycle of latency
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= prod;
      for (int i = 1; i < LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign C = pipe_q[LAT-1];

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one multiplier.
// One operation in flight; result returned to its owner.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [31:0]       resp_c,
  output logic              busy
);

  localparam int TW = width_of(NREQ);
  localparam int CW = width_of(MUL_LAT);

  state_e          state_q;
  state_e          state_d;
  logic [TW-1:0]   rr_q;
  logic [TW-1:0]   rr_d;
  logic [TW-1:0]   tag_q;
  logic [TW-1:0]   tag_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [31:0]     a_q;
  logic [31:0]     a_d;
  logic [31:0]     b_q;
  logic [31:0]     b_d;
  logic [31:0]     mul_c;
  logic [TW-1:0]   grant;
  logic            grant_hit;
  logic            rst_n;

  assign rst_n = ~rst;

  // first valid requester at or above rr_q, wrapping
  always_comb begin
    grant_hit = 1'b0;
    grant     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_hit &&
          req_valid[TW'(rr_add(int'(rr_q), i, NREQ))]) begin
        grant_hit = 1'b1;
        grant     = TW'(rr_add(int'(rr_q), i, NREQ));
      end
    end
  end

  // handshake outputs; result bus only driven in RESP
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_c     = '0;
    if (!rst && state_q == IDLE && grant_hit) begin
      req_ready[grant] = 1'b1;
    end
    if (state_q == RESP) begin
      resp_valid[tag_q] = 1'b1;
      resp_c            = mul_c;
    end
  end

  assign busy = (state_q != IDLE);

  // next state: accept, wait out latency, hold result
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (grant_hit) begin
          a_d     = req_a[32*int'(grant) +: 32];
          b_d     = req_b[32*int'(grant) +: 32];
          tag_d   = grant;
          rr_d    = TW'(rr_add(int'(grant), 1, NREQ));
          cnt_d   = CW'(MUL_LAT - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready[tag_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and operand registers
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  mul #(
    .LAT (MUL_LAT)
  ) u_mul (
    .CLK   (CLK),
    .rst_n (rst_n),
    .A     (a_q),
    .B     (b_q),
    .C     (mul_c)
  );

endmodule
